// File: rtl/fft_pkg.sv
// Shared constants, state encoding and helpers for the radix-2 FFT controllers.
package fft_pkg;

    // Default transform size exponent (N = 16).
    localparam int DEF_LOG2N = 4;

    // Sample RAM and twiddle ROM return data one cycle after the address.
    localparam int RD_LAT = 1;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } fft_state_e;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_r2_addr_gen.sv
// Combinational radix-2 address generator: (stage, butterfly index) ->
// (upper leg, lower leg, twiddle index). Shared by the DIF and DIT controllers.
module fft_r2_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic [3:0]       stage_i,
    input  logic [LOG2N-2:0] b_i,
    output logic [LOG2N-1:0] i1_o,
    output logic [LOG2N-1:0] i2_o,
    output logic [LOG2N-2:0] tw_o
);

    logic [3:0]       p_s;
    logic [LOG2N-1:0] b_ext_s;
    logic [LOG2N-1:0] low_mask_s;
    logic [LOG2N-1:0] half_s;
    logic [LOG2N-1:0] tw_full_s;

    // Insert a zero at bit p of b for i1, OR in the half span for i2, and
    // scale the within-group offset by 2^s to index the twiddle ROM.
    always_comb begin
        b_ext_s = {1'b0, b_i};
        if (stage_i < 4'(LOG2N)) begin
            p_s = 4'(LOG2N - 1) - stage_i;
        end else begin
            p_s = 4'd0;
        end
        low_mask_s = ~({LOG2N{1'b1}} << p_s);
        half_s     = {{(LOG2N-1){1'b0}}, 1'b1} << p_s;
        i1_o       = ((b_ext_s & ~low_mask_s) << 1'b1) | (b_ext_s & low_mask_s);
        i2_o       = i1_o | half_s;
        tw_full_s  = (b_ext_s & low_mask_s) << stage_i;
        tw_o       = tw_full_s[LOG2N-2:0];
    end

endmodule

// File: rtl/fft_r2_sequencer.sv
// In-place radix-2 DIF FFT controller: issues N/2 butterfly reads per stage,
// delays each read's addresses by the RAM+butterfly latency for write-back,
// and drains the pipeline between stages so a stage never reads stale data.
module fft_r2_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N  = DEF_LOG2N,
    parameter int BF_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       Stage,
    output logic             Rd_En,
    output logic [LOG2N-1:0] Rd_Addr0,
    output logic [LOG2N-1:0] Rd_Addr1,
    output logic [LOG2N-2:0] Tw_Addr,
    output logic             Wr_En,
    output logic [LOG2N-1:0] Wr_Addr0,
    output logic [LOG2N-1:0] Wr_Addr1
);

    // Read-to-write distance in cycles.
    localparam int D = RD_LAT + BF_LAT;

    localparam logic [LOG2N-2:0] B_LAST = {(LOG2N-1){1'b1}};
    localparam logic [3:0]       S_LAST = 4'(LOG2N - 1);

    fft_state_e state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic [LOG2N-2:0] b_q, b_d;

    logic [LOG2N-1:0] gen_i1_s;
    logic [LOG2N-1:0] gen_i2_s;
    logic [LOG2N-2:0] gen_tw_s;

    logic             rd_en_q;
    logic [LOG2N-1:0] rd_a0_q;
    logic [LOG2N-1:0] rd_a1_q;
    logic [LOG2N-2:0] tw_q;
    logic             busy_q;
    logic             done_q;

    logic [D-1:0]            dl_valid_q;
    logic [D-1:0][LOG2N-1:0] dl_a0_q;
    logic [D-1:0][LOG2N-1:0] dl_a1_q;
    logic                    pending_s;

    // Addresses are generated for the next (stage, b) so they can be registered
    // alongside Rd_En and appear in the same cycle as the strobe.
    fft_r2_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage_i (s_d),
        .b_i     (b_d),
        .i1_o    (gen_i1_s),
        .i2_o    (gen_i2_s),
        .tw_o    (gen_tw_s)
    );

    // A write is still outstanding if any non-tail slot is valid; the tail
    // slot is being written this very cycle, so it does not hold DRAIN.
    always_comb begin
        pending_s = 1'b0;
        for (int k = 0; k < D - 1; k++) begin
            pending_s = pending_s | dl_valid_q[k];
        end
    end

    // Next-state logic for the stage/butterfly walk.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    s_d     = 4'd0;
                    b_d     = {(LOG2N-1){1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (b_q == B_LAST) begin
                    state_d = DRAIN;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            DRAIN: begin
                if (pending_s) begin
                    state_d = DRAIN;
                end else if (s_q == S_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                    s_d     = s_q + 4'd1;
                    b_d     = {(LOG2N-1){1'b0}};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, stage and butterfly index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            b_q     <= {(LOG2N-1){1'b0}};
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
        end
    end

    // Registered read strobe, read/twiddle addresses and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en_q <= 1'b0;
            rd_a0_q <= {LOG2N{1'b0}};
            rd_a1_q <= {LOG2N{1'b0}};
            tw_q    <= {(LOG2N-1){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rd_en_q <= (state_d == RUN);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            if (state_d == RUN) begin
                rd_a0_q <= gen_i1_s;
                rd_a1_q <= gen_i2_s;
                tw_q    <= gen_tw_s;
            end
        end
    end

    // Write-back delay line: each read's leg addresses reappear D cycles later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_valid_q <= {D{1'b0}};
            dl_a0_q    <= '0;
            dl_a1_q    <= '0;
        end else begin
            dl_valid_q[0] <= rd_en_q;
            dl_a0_q[0]    <= rd_a0_q;
            dl_a1_q[0]    <= rd_a1_q;
            for (int k = 1; k < D; k++) begin
                dl_valid_q[k] <= dl_valid_q[k-1];
                dl_a0_q[k]    <= dl_a0_q[k-1];
                dl_a1_q[k]    <= dl_a1_q[k-1];
            end
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Stage    = s_q;
    assign Rd_En    = rd_en_q;
    assign Rd_Addr0 = rd_a0_q;
    assign Rd_Addr1 = rd_a1_q;
    assign Tw_Addr  = tw_q;
    assign Wr_En    = dl_valid_q[D-1];
    assign Wr_Addr0 = dl_a0_q[D-1];
    assign Wr_Addr1 = dl_a1_q[D-1];

endmodule

// File: tb/tb_fft_r2_sequencer.sv
// Scoreboard bench for fft_r2_sequencer (N=16). Expected reads/writes are
// generated group-by-group when Start is driven and popped as strobes appear.
module tb_fft_r2_sequencer;

    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int NH    = 8;
    localparam int D     = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;

    logic       Busy, Done, Rd_En, Wr_En;
    logic [3:0] Stage, Rd_Addr0, Rd_Addr1, Wr_Addr0, Wr_Addr1;
    logic [2:0] Tw_Addr;

    logic       busy_b0, done_b0, rd_en_b0, wr_en_b0;
    logic [3:0] stage_b0, rd_a0_b0, rd_a1_b0, wr_a0_b0, wr_a1_b0;
    logic [2:0] tw_b0;
    logic       busy_b3, done_b3, rd_en_b3, wr_en_b3;
    logic [3:0] stage_b3, rd_a0_b3, rd_a1_b3, wr_a0_b3, wr_a1_b3;
    logic [2:0] tw_b3;

    always #5 clk = ~clk;

    fft_r2_sequencer #(.LOG2N(LOG2N), .BF_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .Start(start), .Busy(Busy), .Done(Done),
        .Stage(Stage), .Rd_En(Rd_En), .Rd_Addr0(Rd_Addr0), .Rd_Addr1(Rd_Addr1),
        .Tw_Addr(Tw_Addr), .Wr_En(Wr_En), .Wr_Addr0(Wr_Addr0), .Wr_Addr1(Wr_Addr1)
    );

    fft_r2_sequencer #(.LOG2N(LOG2N), .BF_LAT(0)) u_dut_b0 (
        .clk(clk), .reset(reset), .Start(start), .Busy(busy_b0), .Done(done_b0),
        .Stage(stage_b0), .Rd_En(rd_en_b0), .Rd_Addr0(rd_a0_b0), .Rd_Addr1(rd_a1_b0),
        .Tw_Addr(tw_b0), .Wr_En(wr_en_b0), .Wr_Addr0(wr_a0_b0), .Wr_Addr1(wr_a1_b0)
    );

    fft_r2_sequencer #(.LOG2N(LOG2N), .BF_LAT(3)) u_dut_b3 (
        .clk(clk), .reset(reset), .Start(start), .Busy(busy_b3), .Done(done_b3),
        .Stage(stage_b3), .Rd_En(rd_en_b3), .Rd_Addr0(rd_a0_b3), .Rd_Addr1(rd_a1_b3),
        .Tw_Addr(tw_b3), .Wr_En(wr_en_b3), .Wr_Addr0(wr_a0_b3), .Wr_Addr1(wr_a1_b3)
    );

    typedef struct {
        int cyc;
        int s;
        int a0;
        int a1;
        int tw;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int t0 = 1000000;
    int exp_done = -1;
    bit mon_en = 1'b0;
    int rd_cnt, wr_cnt, done_cnt;
    int done_all_cnt = 0;
    int done_b0_cyc = -1;
    int done_b3_cyc = -1;
    int pend_wr[N];
    int addr_cnt[LOG2N][N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_run();
        rd_q.delete();
        wr_q.delete();
        rd_cnt = 0;
        wr_cnt = 0;
        done_cnt = 0;
        for (int a = 0; a < N; a++) begin
            pend_wr[a] = -1;
            for (int s = 0; s < LOG2N; s++) addr_cnt[s][a] = 0;
        end
    endtask

    // Expected schedule: stage s walks groups of 2h points, legs j and j+h.
    task automatic push_transform(input int start_cyc);
        exp_t e;
        for (int s = 0; s < LOG2N; s++) begin
            int h;
            h = NH >> s;
            for (int g = 0; g < N; g += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    e.cyc = start_cyc + 1 + s * (NH + D) + (g / (2 * h)) * h + j;
                    e.s   = s;
                    e.a0  = g + j;
                    e.a1  = g + j + h;
                    e.tw  = (j << s) & 7;
                    rd_q.push_back(e);
                    e.cyc = e.cyc + D;
                    wr_q.push_back(e);
                end
            end
        end
    endtask

    task automatic end_checks();
        check_eq("rd_count", rd_cnt, LOG2N * NH);
        check_eq("wr_count", wr_cnt, LOG2N * NH);
        check_eq("done_count", done_cnt, 1);
        check_eq("rd_left", rd_q.size(), 0);
        check_eq("wr_left", wr_q.size(), 0);
        for (int s = 0; s < LOG2N; s++)
            for (int a = 0; a < N; a++)
                check_eq("addr_once", addr_cnt[s][a], 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, Busy, 0);
        check_eq({tag, "_done"}, Done, 0);
        check_eq({tag, "_stage"}, Stage, 0);
        check_eq({tag, "_rd_en"}, Rd_En, 0);
        check_eq({tag, "_rd_a0"}, Rd_Addr0, 0);
        check_eq({tag, "_rd_a1"}, Rd_Addr1, 0);
        check_eq({tag, "_tw"}, Tw_Addr, 0);
        check_eq({tag, "_wr_en"}, Wr_En, 0);
        check_eq({tag, "_wr_a0"}, Wr_Addr0, 0);
        check_eq({tag, "_wr_a1"}, Wr_Addr1, 0);
    endtask

    // Monitor: compare strobes against the scoreboard on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (Done) done_all_cnt++;
        if (done_b0) done_b0_cyc = cyc;
        if (done_b3) done_b3_cyc = cyc;
        if (mon_en) begin
            check_eq("busy", int'(Busy), int'(cyc >= t0 + 1 && cyc <= exp_done));
            if (Done) begin
                done_cnt++;
                check_eq("done_cyc", cyc, exp_done);
            end
            if (Rd_En) begin
                rd_cnt++;
                if (rd_q.size() == 0) begin
                    check_eq("rd_extra", cyc, -1);
                end else begin
                    e = rd_q.pop_front();
                    check_eq("rd_cyc", cyc, e.cyc);
                    check_eq("rd_a0", Rd_Addr0, e.a0);
                    check_eq("rd_a1", Rd_Addr1, e.a1);
                    check_eq("rd_tw", Tw_Addr, e.tw);
                    check_eq("rd_stage", Stage, e.s);
                    check_eq("rd_hazard0", int'(pend_wr[Rd_Addr0] < cyc), 1);
                    check_eq("rd_hazard1", int'(pend_wr[Rd_Addr1] < cyc), 1);
                    pend_wr[Rd_Addr0] = cyc + D;
                    pend_wr[Rd_Addr1] = cyc + D;
                end
            end
            if (Wr_En) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    check_eq("wr_extra", cyc, -1);
                end else begin
                    e = wr_q.pop_front();
                    check_eq("wr_cyc", cyc, e.cyc);
                    check_eq("wr_a0", Wr_Addr0, e.a0);
                    check_eq("wr_a1", Wr_Addr1, e.a1);
                    addr_cnt[e.s][Wr_Addr0]++;
                    addr_cnt[e.s][Wr_Addr1]++;
                end
            end
        end
    end

    // Begin a tracked transform with Start driven in the current cycle.
    task automatic arm_transform();
        clear_run();
        t0 = cyc;
        exp_done = t0 + 1 + LOG2N * (NH + D);
        push_transform(t0);
        mon_en = 1'b1;
    endtask

    initial begin
        int k;
        int done_before;

        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single Start pulse, default latency; also BF_LAT=0/3 Done timing.
        arm_transform();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!Done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_seen", Done, 1);
        repeat (12) @(negedge clk);
        end_checks();
        check_eq("b0_done_cyc", done_b0_cyc, t0 + 1 + LOG2N * (NH + 1));
        check_eq("b3_done_cyc", done_b3_cyc, t0 + 1 + LOG2N * (NH + 4));
        repeat (10) @(negedge clk);

        // Start held high through the DONE cycle: exactly one transform.
        arm_transform();
        start = 1'b1;
        repeat (42) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        end_checks();
        repeat (20) @(negedge clk);

        // Extra Start pulses mid-run and in the DONE cycle are ignored.
        arm_transform();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (35) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        end_checks();
        repeat (20) @(negedge clk);

        // Reset asserted mid-transform: outputs clear at once, no Done.
        arm_transform();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        mon_en = 1'b0;
        done_before = done_all_cnt;
        #1 reset = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        check_eq("midrst_no_done", done_all_cnt, done_before);

        // Restart after reset: sequence begins again from stage 0.
        arm_transform();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        end_checks();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_r2_sequencer.md
Name: fft_r2_sequencer

Overview:
- Controls an in-place radix-2 DIF FFT of N = 2^LOG2N complex points.
- Drives one shared Butterfly_Radix2 datapath, one dual-port sample RAM and one twiddle ROM.
- On Start it runs LOG2N stages of N/2 butterflies, then pulses Done.
- Generates read, twiddle and write-back addresses, and inserts a drain gap between stages so no read-after-write hazard can occur.

Parameters:
- LOG2N, 4, log2 of transform size. Legal range 2..15.
- BF_LAT, 1, pipeline latency of the butterfly in cycles. Legal range 0..7.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin transform; sampled only in IDLE.
- Busy  out  1  high from the first RUN cycle through the DONE cycle.
- Done  out  1  one-cycle pulse when the transform is complete.
- Stage  out  4  current stage index s (0..LOG2N-1).
- Rd_En  out  1  RAM read strobe for both ports.
- Rd_Addr0  out  LOG2N  address i1 (upper butterfly leg).
- Rd_Addr1  out  LOG2N  address i2 = i1 + h.
- Tw_Addr  out  LOG2N-1  twiddle ROM address, issued with Rd_En.
- Wr_En  out  1  RAM write strobe for Y0/Y1.
- Wr_Addr0  out  LOG2N  write address for Y0 (equals the i1 of the matching read).
- Wr_Addr1  out  LOG2N  write address for Y1 (equals the i2 of the matching read).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. Busy, Done, Rd_En and Wr_En are 0. All address outputs, Stage, b and the delay line are 0.
- Constants:
  - RD_LAT=1: RAM and ROM data are valid the cycle after the address is presented.
  - D = RD_LAT + BF_LAT.
- Address generation for stage s and butterfly index b (0..N/2-1):
  - Half span h = N >> (s+1).
  - p = LOG2N-1-s.
  - i1 = b with a 0 bit inserted at bit position p.
  - i2 = i1 | h.
  - Tw_Addr = (b mod h) << s, truncated to LOG2N-1 bits.
- State IDLE:
  - Start=1 moves to RUN with s=0, b=0.
  - All strobes are 0.
- State RUN:
  - Rd_En=1 every cycle, with addresses for (s, b). b increments each cycle.
  - At b = N/2-1, move to DRAIN.
- Write-back delay line:
  - D stages deep, carrying {valid, i1, i2}.
  - Wr_En, Wr_Addr0 and Wr_Addr1 equal the delay-line tail. A write therefore occurs exactly D cycles after its read.
- State DRAIN:
  - Rd_En=0. Wait until the delay line holds no valid entry; the last write of the stage lands in the final DRAIN cycle.
  - If s < LOG2N-1: s increments, b=0, return to RUN. The next stage's first read is the cycle after the last write.
  - Otherwise go to DONE.
- State DONE: Done=1 for one cycle, then IDLE. Busy falls with the return to IDLE.
- Timing:
  - If Start is sampled at cycle 0, the first Rd_En is at cycle 1.
  - Each stage takes N/2 + D cycles.
  - Done is at cycle 1 + LOG2N*(N/2+D).
- Start outside IDLE, including in the DONE cycle, is ignored and not queued.
- Reset mid-operation: immediate return to IDLE. Pending writes are discarded (Wr_En drops asynchronously). No Done pulse is produced.
- Stage is held between transforms (0 after reset). It updates on each RUN entry.

Decomposition:
- Package fft_pkg holds:
  - default LOG2N;
  - RD_LAT=1;
  - state encoding IDLE/RUN/DRAIN/DONE as 2-bit localparams;
  - function clog2.
- Sub-module fft_r2_addr_gen: combinational (Stage, b) -> (i1, i2, tw). It is reused by the future radix-2 DIT controller.
- The delay line and FSM stay in fft_r2_sequencer.

Test Plan:
- Defaults (N=16, BF_LAT=1), Start pulse at cycle 0 -> first Rd_En at cycle 1 with (i1,i2,tw) = (0,8,0).
  - Cycle 2: (1,9,1). Cycle 8: (7,15,7).
  - Wr_En on cycles 3..10 with Wr_Addr0/Wr_Addr1 = 0/8 .. 7/15.
- Stage 1 reads begin at cycle 11: (0,4,0), (1,5,2), (2,6,4), (3,7,6), (8,12,0).
  - Stage 3 reads: (0,1,0), (2,3,0) ... (14,15,0).
  - No read of an address occurs in the same cycle as, or before, its pending write.
- Full run -> Done high only at cycle 41 for exactly one cycle; Busy high over cycles 1..41.
  - Exactly 32 Rd_En and 32 Wr_En pulses.
  - Every RAM address appears once per stage across Wr_Addr0/Wr_Addr1.
- BF_LAT=0, N=16 -> stage length 9 cycles, Done at cycle 37. BF_LAT=3 -> Done at cycle 49.
- Start held high continuously, and pulses at cycles 5 and 41 -> a single transform only. A new transform starts only from Start sampled in IDLE (cycle 42 or later).
- reset=0 asserted at cycle 15 for 2 cycles -> all outputs 0 asynchronously, no Done pulse.
  - After reset=1 and a Start pulse, the sequence restarts from stage 0 with the first read (0,8,0).
